// File: rtl/alu_wb_buffer_if.sv
// Bus bundle between the ALU result port, the writeback buffer and the CDB port.
// Handshake: a transfer happens at a rising clk edge when valid and ready are both
// high. The producer holds valid and its payload steady until that edge. The
// consumer may drive ready either way, but ready must not be derived from valid.
interface alu_wb_buffer_if #(
    parameter int DATA_WIDTH      = 32,
    parameter int PHYS_ADDR_WIDTH = 6,
    parameter int ROB_WIDTH       = 5
);
    logic                       in_valid;
    logic                       in_ready;
    logic [DATA_WIDTH-1:0]      in_result;
    logic [PHYS_ADDR_WIDTH-1:0] in_prd;
    logic [ROB_WIDTH-1:0]       in_rob_idx;
    logic                       cdb_valid;
    logic                       cdb_ready;
    logic [DATA_WIDTH-1:0]      cdb_result;
    logic [PHYS_ADDR_WIDTH-1:0] cdb_prd;
    logic [ROB_WIDTH-1:0]       cdb_rob_idx;

    // ALU-side producer and CDB-side arbiter, as seen by the environment.
    modport master (
        output in_valid, in_result, in_prd, in_rob_idx, cdb_ready,
        input  in_ready, cdb_valid, cdb_result, cdb_prd, cdb_rob_idx
    );

    // The writeback buffer itself.
    modport slave (
        input  in_valid, in_result, in_prd, in_rob_idx, cdb_ready,
        output in_ready, cdb_valid, cdb_result, cdb_prd, cdb_rob_idx
    );
endinterface

// File: rtl/alu_wb_buffer.sv
// ALU writeback buffer: a small FIFO that holds ALU results (result, dest tag,
// ROB index) until the CDB arbiter grants this port. Flush discards everything.
// Optional feature macro: ALU_WB_BYPASS_EN -- when defined, a result arriving
// while the buffer is empty and the CDB is granting goes straight to the CDB
// in the same cycle without being stored.
module alu_wb_buffer #(
    parameter int DATA_WIDTH      = 32,
    parameter int PHYS_ADDR_WIDTH = 6,
    parameter int ROB_WIDTH       = 5,
    parameter int DEPTH           = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    alu_wb_buffer_if.slave           bus,
    output logic [$clog2(DEPTH):0]   occupancy
);
    localparam int IW = $clog2(DEPTH);

    typedef struct packed {
        logic [DATA_WIDTH-1:0]      result;
        logic [PHYS_ADDR_WIDTH-1:0] prd;
        logic [ROB_WIDTH-1:0]       rob_idx;
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        in_entry;
    entry_t        head;
    logic [IW:0]   wr_ptr;
    logic [IW:0]   rd_ptr;
    logic          empty;
    logic          full;
    logic          bypass;
    logic          push;
    logic          pop;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]) && (wr_ptr[IW] != rd_ptr[IW]);

`ifdef ALU_WB_BYPASS_EN
    assign bypass = empty & ~flush & bus.in_valid & bus.cdb_ready;
`else
    assign bypass = 1'b0;
`endif

    // Flush wins over both sides; a bypassed result is never stored.
    assign push = bus.in_valid & ~full & ~flush & ~bypass;
    assign pop  = ~empty & ~flush & bus.cdb_ready;

    assign in_entry  = '{result: bus.in_result, prd: bus.in_prd, rob_idx: bus.in_rob_idx};
    assign head      = mem[rd_ptr[IW-1:0]];
    assign occupancy = wr_ptr - rd_ptr;

    // Input side only looks at registered state, so a full buffer refuses input
    // even in a cycle where the head is being granted.
    assign bus.in_ready = ~full;

    // CDB presentation: head entry, or the incoming result when bypassing.
    always_comb begin
        bus.cdb_valid   = ~empty & ~flush;
        bus.cdb_result  = head.result;
        bus.cdb_prd     = head.prd;
        bus.cdb_rob_idx = head.rob_idx;
        if (bypass) begin
            bus.cdb_valid   = 1'b1;
            bus.cdb_result  = in_entry.result;
            bus.cdb_prd     = in_entry.prd;
            bus.cdb_rob_idx = in_entry.rob_idx;
        end
    end

    // Pointer update; flush returns both pointers to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Entry storage; cleared on reset so the CDB data bus reads zero afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push) begin
            mem[wr_ptr[IW-1:0]] <= in_entry;
        end
    end
endmodule
